mem_bus_arbiter: RTL
====================

// Module: mem_bus_arbiter
// PURPOSE
//  N-way arbiter for the shared memory bus (I-cache, D-cache, prefetch, DMA clients). Grants one
//  requester, holds the grant for a whole multi-beat transaction until bus_done, then hands over.
//  Handover to the next requester has no idle cycle. Policy is round-robin or fixed priority.
//  A watchdog flags transactions that hold the bus too long.
// PARAMETERS
//  NUM_REQ   4  number of requesters, >=2; index 0 = highest priority in fixed mode
//  ARB_MODE  0  0 = round-robin, 1 = fixed priority (lowest index wins)
//  MAX_HOLD  64 cycles in GRANT before hold_timeout pulses; 0 disables watchdog
//  IDX_W     $clog2(NUM_REQ)  derived; do not override
// PORTS
//  clk           in   1        system clock, rising edge
//  reset         in   1        asynchronous, active-low reset (0 = in reset)
//  req           in   NUM_REQ  per-requester request level; held until served or withdrawn
//  bus_done      in   1        memory side: current owner's transaction completes this cycle
//  grant         out  NUM_REQ  registered one-hot grant; all-zero when idle
//  grant_valid   out  1        registered; equals |grant
//  grant_idx     out  IDX_W    registered binary index of owner; 0 when idle
//  hold_timeout  out  1        registered one-cycle pulse when owner reaches MAX_HOLD cycles
// BEHAVIOUR
//  Reset (asynchronous on reset==0, immediate, also mid-transaction):
//   grant=0, grant_valid=0, grant_idx=0, hold_timeout=0, state=IDLE, hold_cnt=0, rr_ptr=NUM_REQ-1.
//   Result: req[0] wins the first tie.
//  FSM states: IDLE, GRANT. All outputs come from flops. Grant latency is 1 cycle.
//  IDLE, |req at edge t: winner is granted at t+1 and state goes to GRANT. bus_done is ignored.
//  GRANT: grant is held stable while req[owner]=1 and bus_done=0. Other requests have no effect.
//  Release at edge t happens when bus_done=1 OR req[owner]=0 (abandon). Either way:
//   - other req pending: new winner granted at t+1, state stays GRANT, no idle gap
//   - only owner still requesting: owner may be re-granted (RR naturally rotates past it)
//   - no req: grant=0, state goes to IDLE at t+1
//  Winner selection:
//   - RR: first set req scanning from rr_ptr+1 upward, wrapping NUM_REQ-1 -> 0.
//     rr_ptr is loaded with the winner index on every new grant.
//   - Fixed: lowest set index. rr_ptr is still updated but unused.
//   - One winner only. grant is always one-hot or zero. grant_idx always matches grant.
//  Watchdog:
//   - hold_cnt clears to 0 on each new grant and increments each GRANT cycle.
//   - hold_cnt is $clog2(MAX_HOLD+1) bits and saturates at MAX_HOLD.
//   - hold_timeout=1 for exactly the one cycle after hold_cnt reaches MAX_HOLD.
//   - The grant is NOT revoked. The pulse is informational, for the debug/perf counter.
//  X-safety: req bits outside the winner are don't-care in GRANT. bus_done is qualified by state.
// STRUCTURE
//  mem_arb_pkg: arb_state_e {IDLE, GRANT}; arb_mode_e {ARB_RR=0, ARB_FIXED=1};
//   function onehot2idx; localparam for default NUM_REQ.
//  Sub-module rr_pick #(N):
//   - combinational masked priority picker (req, start_ptr, mode) -> (found, win_idx, win_onehot)
//   - implemented as double-width rotate-and-priority-encode
//  Top module: FSM, grant/idx registers, rr_ptr, hold counter. One always_ff, one always_comb next-state.
// TESTING
//  1. reset release, req=4'b1111 held, bus_done pulsed every 3rd GRANT cycle -> grant_idx sequence
//     0,1,2,3,0; each grant held exactly 3 cycles; no idle gap.
//  2. ARB_MODE=1, req=4'b1010, done every cycle -> grant_idx stays 1 until req[1] drops,
//     then 3 on the next cycle.
//  3. IDLE, req[2] rises at t -> grant=4'b0100 at t+1; req[0] rises at t+2 -> no change;
//     bus_done at t+4 -> grant=4'b0001 at t+5.
//  4. Abandon: owner 1 drops req without bus_done, req=0 otherwise -> grant=0 and state IDLE
//     the next cycle; a stray bus_done in IDLE is ignored.
//  5. MAX_HOLD=8, single requester held 20 cycles -> hold_timeout high exactly once,
//     9 cycles after grant; grant stays asserted.
//  6. reset driven low mid-GRANT (owner 3) -> all outputs 0 immediately, without waiting for
//     a clock; after release, req=4'b1001 -> grant_idx=0 first.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory bus arbiter: FSM state, arbitration mode,
// default requester count and a one-hot to binary index helper.
package mem_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  localparam int unsigned DEFAULT_NUM_REQ = 4;
  localparam int unsigned MAX_ONEHOT_W    = 32;

  // OR-reduction of set bit positions; exact for one-hot or all-zero inputs.
  function automatic int unsigned onehot2idx(input logic [MAX_ONEHOT_W-1:0] onehot);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MAX_ONEHOT_W; i++) begin
      if (onehot[i]) begin
        idx = idx | i;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_pick.sv
// Combinational masked priority picker: rotates the request vector so the search starts
// just after start_ptr (round-robin) or at index 0 (fixed), then takes the lowest set bit.
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start_ptr,
  input  arb_mode_e        mode,
  output logic             found,
  output logic [IDX_W-1:0] win_idx,
  output logic [N-1:0]     win_onehot
);

  logic [IDX_W-1:0] first_idx;
  logic [2*N-1:0]   doubled;
  logic [N-1:0]     rotated;
  int unsigned      offset;
  int unsigned      winner;

  always_comb begin
    first_idx = '0;
    if (mode == ARB_RR && start_ptr != IDX_W'(N - 1)) begin
      first_idx = start_ptr + 1'b1;
    end

    // Doubling the vector makes the wrap-around a plain right shift.
    doubled = {req, req} >> first_idx;
    rotated = doubled[N-1:0];

    found  = 1'b0;
    offset = 0;
    for (int unsigned i = N; i > 0; i--) begin
      if (rotated[i-1]) begin
        found  = 1'b1;
        offset = i - 1;
      end
    end

    winner = 32'(first_idx) + offset;
    if (winner >= N) begin
      winner = winner - N;
    end

    win_onehot = '0;
    for (int unsigned i = 0; i < N; i++) begin
      win_onehot[i] = found && (winner == i);
    end
    win_idx = IDX_W'(onehot2idx(32'(win_onehot)));
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shared memory bus arbiter: grants one requester per multi-beat transaction, hands over
// without an idle cycle on bus_done or abandon, and flags owners that hold the bus too long.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = DEFAULT_NUM_REQ,
  parameter int unsigned ARB_MODE = 0,
  parameter int unsigned MAX_HOLD = 64,
  parameter int unsigned IDX_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               bus_done,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               hold_timeout
);

  localparam int unsigned      CNT_W    = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam arb_mode_e        MODE     = (ARB_MODE == 1) ? ARB_FIXED : ARB_RR;

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic               hold_timeout_q, hold_timeout_d;
  logic               wd_fired_q, wd_fired_d;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] pick_onehot;
  logic               owner_release;
  logic               arbitrate;

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req        (req),
    .start_ptr  (rr_ptr_q),
    .mode       (MODE),
    .found      (pick_found),
    .win_idx    (pick_idx),
    .win_onehot (pick_onehot)
  );

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    grant_idx_d    = grant_idx_q;
    rr_ptr_d       = rr_ptr_q;
    hold_cnt_d     = hold_cnt_q;
    hold_timeout_d = 1'b0;
    wd_fired_d     = wd_fired_q;

    owner_release = (state_q == GRANT) && (bus_done || !req[grant_idx_q]);
    arbitrate     = (state_q == IDLE) || owner_release;

    // wd_fired keeps the pulse to a single cycle while the saturated count sits at max.
    if (MAX_HOLD != 0 && state_q == GRANT && hold_cnt_q == HOLD_MAX && !wd_fired_q) begin
      hold_timeout_d = 1'b1;
      wd_fired_d     = 1'b1;
    end

    if (arbitrate) begin
      hold_cnt_d = '0;
      wd_fired_d = 1'b0;
      if (pick_found) begin
        state_d     = GRANT;
        grant_d     = pick_onehot;
        grant_idx_d = pick_idx;
        rr_ptr_d    = pick_idx;
      end else begin
        state_d     = IDLE;
        grant_d     = '0;
        grant_idx_d = '0;
      end
    end else if (hold_cnt_q != HOLD_MAX) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      grant_q        <= '0;
      grant_idx_q    <= '0;
      rr_ptr_q       <= IDX_W'(NUM_REQ - 1);
      hold_cnt_q     <= '0;
      hold_timeout_q <= 1'b0;
      wd_fired_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      grant_idx_q    <= grant_idx_d;
      rr_ptr_q       <= rr_ptr_d;
      hold_cnt_q     <= hold_cnt_d;
      hold_timeout_q <= hold_timeout_d;
      wd_fired_q     <= wd_fired_d;
    end
  end

  assign grant        = grant_q;
  assign grant_valid  = (state_q == GRANT);
  assign grant_idx    = grant_idx_q;
  assign hold_timeout = hold_timeout_q;

endmodule
